// File: rtl/bcd2bin_arbiter_wfs.sv
// -----------------------------------------------------------------------------
// bcd2bin_arbiter_wfs
//   Shared, iterative 4-digit BCD-to-binary converter serving two requesters.
//   A round-robin arbiter grants one request at a time. The granted operand is
//   loaded into a 30-bit shifter and converted by reverse double-dabble
//   (shift right, then subtract 3 from every BCD field >= 8) over 14 iterations.
//
//   Optional build macro: BCD2BIN_DUAL_STEP_EN
//     defined   : two iterations per clock, conversion takes 7 SHIFT cycles
//     undefined : one iteration per clock, conversion takes 14 SHIFT cycles
//
// Ports
//   clk_wfs             in   system clock, rising edge
//   rst_wfs             in   asynchronous active-high reset
//   req0_wfs/req1_wfs   in   level conversion requests
//   bcd0_wfs/bcd1_wfs   in   16-bit BCD operands {thou,hund,tens,ones}
//   ack0_wfs/ack1_wfs   out  one-cycle pulse, operand captured
//   done0_wfs/done1_wfs out  one-cycle pulse, result valid
//   bin_wfs             out  last result, held until next done
//   err_wfs             out  last operand had a digit > 9, held
//   busy_wfs            out  high while converting
//
// FSM states
//   state   | meaning
//   S_IDLE  | waiting for a request; arbitration and operand capture
//   S_SHIFT | iterating the shift/correct datapath
// -----------------------------------------------------------------------------
module bcd2bin_arbiter_wfs #(
  parameter int BIN_W = 14
) (
  input  logic             clk_wfs,
  input  logic             rst_wfs,
  input  logic             req0_wfs,
  input  logic [15:0]      bcd0_wfs,
  input  logic             req1_wfs,
  input  logic [15:0]      bcd1_wfs,
  output logic             ack0_wfs,
  output logic             ack1_wfs,
  output logic             done0_wfs,
  output logic             done1_wfs,
  output logic [BIN_W-1:0] bin_wfs,
  output logic             err_wfs,
  output logic             busy_wfs
);

  localparam int SH_W = BIN_W + 16;

`ifdef BCD2BIN_DUAL_STEP_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam logic [3:0] CNT_INC  = 4'(STEP);
  localparam logic [3:0] CNT_LAST = 4'(BIN_W - STEP);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [SH_W-1:0] r_shift;
  logic [3:0]      r_cnt;
  logic            r_invalid;
  logic            r_id;      // requester owning the conversion in flight
  logic            r_last;    // requester served most recently

  logic            w_any_req;
  logic            w_gnt_id;
  logic [15:0]     w_bcd_sel;
  logic            w_bad_sel;
  logic            w_load;
  logic            w_finish;
  logic [SH_W-1:0] w_iter1;
  logic [SH_W-1:0] w_iter;

  // One reverse double-dabble iteration on the upper four BCD fields.
  function automatic logic [SH_W-1:0] f_iter(input logic [SH_W-1:0] s);
    logic [SH_W-1:0] t;
    t = s >> 1;
    for (int d = 0; d < 4; d++) begin
      if (t[BIN_W + 4*d + 3]) begin
        t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
    return t;
  endfunction

  function automatic logic f_bad_digit(input logic [15:0] b);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (b[4*d +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  assign w_iter1 = f_iter(r_shift);
`ifdef BCD2BIN_DUAL_STEP_EN
  assign w_iter  = f_iter(w_iter1);
`else
  assign w_iter  = w_iter1;
`endif

  // Arbitration: a lone request wins; on contention the requester not served
  // last wins. r_last resets to 1 so requester 0 goes first.
  assign w_any_req = req0_wfs | req1_wfs;
  assign w_gnt_id  = (req0_wfs & req1_wfs) ? ~r_last : req1_wfs;
  assign w_bcd_sel = w_gnt_id ? bcd1_wfs : bcd0_wfs;
  assign w_bad_sel = f_bad_digit(w_bcd_sel);

  // State register
  always_ff @(posedge clk_wfs or posedge rst_wfs) begin
    if (rst_wfs) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)        w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_load   = 1'b0;
    w_finish = 1'b0;
    busy_wfs = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = w_any_req;
      end
      S_SHIFT: begin
        busy_wfs = 1'b1;
        w_finish = (r_cnt == CNT_LAST);
      end
      default: ;
    endcase
  end

  // Datapath and registered handshake pulses
  always_ff @(posedge clk_wfs or posedge rst_wfs) begin
    if (rst_wfs) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_invalid <= 1'b0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      ack0_wfs  <= 1'b0;
      ack1_wfs  <= 1'b0;
      done0_wfs <= 1'b0;
      done1_wfs <= 1'b0;
      bin_wfs   <= '0;
      err_wfs   <= 1'b0;
    end else begin
      ack0_wfs  <= 1'b0;
      ack1_wfs  <= 1'b0;
      done0_wfs <= 1'b0;
      done1_wfs <= 1'b0;
      if (w_load) begin
        r_shift   <= {w_bcd_sel, {BIN_W{1'b0}}};
        r_invalid <= w_bad_sel;
        r_cnt     <= '0;
        r_id      <= w_gnt_id;
        ack0_wfs  <= ~w_gnt_id;
        ack1_wfs  <= w_gnt_id;
      end else if (r_state == S_SHIFT) begin
        r_shift <= w_iter;
        r_cnt   <= r_cnt + CNT_INC;
        if (w_finish) begin
          bin_wfs   <= r_invalid ? '0 : w_iter[BIN_W-1:0];
          err_wfs   <= r_invalid;
          done0_wfs <= ~r_id;
          done1_wfs <= r_id;
          r_last    <= r_id;
        end
      end
    end
  end

endmodule

// File: doc/bcd2bin_arbiter_wfs.md
Name: bcd2bin_arbiter_wfs

Overview:
- Sequential, shared BCD-to-binary conversion engine for two requesters.
- Round-robin arbiter grants one 4-digit BCD request at a time; iterative shift/subtract-3 datapath runs one iteration per clock.
- Replaces per-requester combinational converters in display/keypad paths; trades latency for area.

Parameters:
- BIN_W, 14, result width and number of shift iterations; legal value 14 only (4 BCD digits); other values unsupported.

Ports:
- clk_wfs  in  1  system clock, rising edge
- rst_wfs  in  1  asynchronous, active-high reset
- req0_wfs  in  1  requester 0 conversion request, level
- bcd0_wfs  in  16  requester 0 BCD operand {thousands,hundreds,tens,ones}
- req1_wfs  in  1  requester 1 conversion request, level
- bcd1_wfs  in  16  requester 1 BCD operand
- ack0_wfs  out  1  one-cycle pulse: requester 0 operand captured
- ack1_wfs  out  1  one-cycle pulse: requester 1 operand captured
- done0_wfs  out  1  one-cycle pulse: result for requester 0 valid
- done1_wfs  out  1  one-cycle pulse: result for requester 1 valid
- bin_wfs  out  14  last conversion result, held until next done
- err_wfs  out  1  last operand had a digit > 9; valid with done, held
- busy_wfs  out  1  high while in SHIFT

Behaviour:
- Reset: state IDLE, all outputs 0, shifter/counter 0, RR pointer selects requester 0 first.
- States: IDLE, SHIFT. No other states.
- IDLE, edge E0 with any req high: grant per round-robin; if both high, grant the requester not served last. Load shifter[29:14] = granted bcd, [13:0] = 0; capture invalid-digit flag (any nibble > 9); count = 0; latch grant ID; state → SHIFT; ack of granted requester high for the cycle after E0.
- SHIFT, edges E1..E14: each edge shifts right by 1, then subtracts 3 from every nibble field [29:26],[25:22],[21:18],[17:14] that is >= 8; count increments.
- At E14: state → IDLE; bin_wfs = shifter[13:0] (0 if invalid flag set); err_wfs = invalid flag; done of latched requester high for one cycle; RR pointer updated to that requester.
- Latency: ack at E0, done at E14; earliest next grant at E15 (throughput 1 per 15 cycles).
- Requests are sampled only in IDLE; req held during SHIFT is ignored, not queued. A req still high at E15 starts a new conversion; requesters drop req after ack.
- Operand captured at E0 only; bcd inputs may change afterwards.
- busy_wfs high from after E0 until E14.
- ack and done never high for both requesters in the same cycle.
- Async reset mid-SHIFT: immediate return to IDLE, outputs cleared, no done pulse for the aborted conversion.

Optional Feature:
- Macro BCD2BIN_DUAL_STEP_EN.
- Defined: two iterations per clock (shift/correct applied twice combinationally). SHIFT lasts edges E1..E7; done at E7; next grant at E8. Results identical.
- Undefined: one iteration per clock as above.

Test Plan:
- Reset, req0 with bcd0=16'h9999 → ack0 pulse after E0, busy 14 cycles, done0 at E14, bin=14'd9999, err=0, done1/ack1 stay 0.
- req0 and req1 high at the same edge, bcd0=16'h0001, bcd1=16'h1234, each dropped after its ack → requester 0 served first (bin=1 at E14), requester 1 granted at E15, done1 at E29 with bin=1234.
- req1 only, bcd1=16'h12A4 → done1 with err=1, bin=0; next req1 16'h0042 → err=0, bin=42.
- req0 16'h0500, assert rst_wfs for 1 cycle at E5 → all outputs 0, no done0; then req0 16'h0007 → done0 with bin=7.
- req1 asserted while busy serving req0 (16'h0000) → ack1 not asserted until E15; done0 bin=0; then requester 1 completes normally.
- With BCD2BIN_DUAL_STEP_EN: bcd0=16'h9999 → done0 at E7, bin=9999; back-to-back req0 regranted at E8.
